// File: rtl/vlg_trig.sv
// Trigger-side controller for an HC-SR04-style ranger: trig pulse, echo handshake, timeout, period holdoff.
// Latency: o_trig rises on the edge that samples i_start in IDLE; o_done/o_timeout pulse one clock after the deciding cycle.
// Backpressure: none; i_start is ignored outside IDLE. Build option VLG_TRIG_AUTO_EN adds i_auto for free-running repeat.
module vlg_trig #(
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clk_en,
  input  logic i_start,
  input  logic i_echo,
`ifdef VLG_TRIG_AUTO_EN
  input  logic i_auto,
`endif
  output logic o_trig,
  output logic o_busy,
  output logic o_done,
  output logic o_timeout
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG    = 3'd1;
  localparam logic [2:0] ST_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  // Terminal counts: a state ends on the tick that would take r_st_cnt to N.
  localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_US - 1);
  localparam logic [15:0] PER_LIM   = 16'(PERIOD_US);

  logic [1:0]  r_echo;
  logic [2:0]  r_state;
  logic [15:0] r_st_cnt;
  logic [15:0] r_per_cnt;
  logic        r_trig;
  logic        r_done;
  logic        r_timeout;

  logic [2:0]  w_nxt_state;
  logic        w_done;
  logic        w_timeout;
  logic        w_st_exp;
  logic        w_auto;

`ifdef VLG_TRIG_AUTO_EN
  assign w_auto = i_auto;
`else
  assign w_auto = 1'b0;
`endif

  assign w_st_exp = i_clk_en && (r_st_cnt == TMO_LAST);

  // Two-flop synchronizer for the asynchronous echo line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_echo <= 2'b00;
    end else begin
      r_echo <= {r_echo[0], i_echo};
    end
  end

  // Next-state decode; an echo edge takes priority over a coincident timeout.
  always_comb begin
    w_nxt_state = r_state;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_nxt_state = ST_TRIG;
      end
      ST_TRIG: begin
        if (i_clk_en && (r_st_cnt == TRIG_LAST)) w_nxt_state = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (r_echo[1]) begin
          w_nxt_state = ST_WAIT_LO;
        end else if (w_st_exp) begin
          w_nxt_state = ST_HOLDOFF;
          w_timeout   = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!r_echo[1]) begin
          w_nxt_state = ST_HOLDOFF;
          w_done      = 1'b1;
        end else if (w_st_exp) begin
          w_nxt_state = ST_HOLDOFF;
          w_timeout   = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (r_per_cnt >= PER_LIM) w_nxt_state = w_auto ? ST_TRIG : ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // State register and registered outputs; trig follows TRIG occupancy edge-for-edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_trig    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_trig    <= (w_nxt_state == ST_TRIG);
      r_done    <= w_done;
      r_timeout <= w_timeout;
    end
  end

  // Per-state tick counter, restarted on every state change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st_cnt <= 16'd0;
    end else if (w_nxt_state != r_state) begin
      r_st_cnt <= 16'd0;
    end else if (i_clk_en && (r_st_cnt != 16'hFFFF)) begin
      r_st_cnt <= r_st_cnt + 16'd1;
    end
  end

  // Trigger-to-trigger period counter, restarted when trig rises and saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_per_cnt <= 16'd0;
    end else if ((w_nxt_state == ST_TRIG) && (r_state != ST_TRIG)) begin
      r_per_cnt <= 16'd0;
    end else if (i_clk_en && (r_per_cnt != 16'hFFFF)) begin
      r_per_cnt <= r_per_cnt + 16'd1;
    end
  end

  assign o_trig    = r_trig;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = r_done;
  assign o_timeout = r_timeout;

endmodule

// File: doc/vlg_trig.md
Name: vlg_trig

Overview:
- Trigger-side controller for the HC-SR04-style ultrasonic ranging interface; the echo-width measurement block consumes the echo line this block provokes.
- Generates the trig pulse, tracks the resulting echo handshake, flags a missing or stuck echo as a timeout, and enforces the minimum measurement period before the next trigger.
- Timing uses the shared 1 us clock-enable tick (i_clk_en).

Parameters:
- TRIG_US, 10: trig high time, in 1 us ticks; legal range 1..65535.
- TIMEOUT_US, 30000: limit for each echo wait, in ticks. Applies separately to the rise wait and to the high time. Must exceed 26011, the maximum legal echo width.
- PERIOD_US, 60000: minimum time from one trigger start to the next trigger start, in ticks. Must be greater than TRIG_US.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_clk_en  in  1  1 us tick; high for exactly one i_clk cycle per microsecond
- i_start  in  1  single-shot measurement request; level-sampled in IDLE only
- i_echo  in  1  raw echo line from the sensor (asynchronous)
- o_trig  out  1  trig output to the sensor; registered
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the echo falls within the timeout
- o_timeout  out  1  one-cycle pulse when either echo wait expires

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (i_clk, i_rst_n). All flops clear on i_rst_n low, including the synchronizer, FSM, counters and outputs.
- Output reset values: o_trig=0, o_busy=0, o_done=0, o_timeout=0, state=IDLE.
- Echo input: i_echo passes through a 2-flop synchronizer (r_echo[1:0]). The FSM uses only the synchronized bit r_echo[1].
- Counters: two 16-bit counters. Both advance only on cycles with i_clk_en=1.
  - r_per_cnt: cleared on TRIG entry, saturates at 16'hFFFF.
  - r_st_cnt: cleared on every state entry.
- FSM states and transitions:
  - IDLE: if i_start=1, go to TRIG on the next edge. o_trig rises on the same edge.
  - TRIG: o_trig=1. When r_st_cnt==TRIG_US-1 and i_clk_en=1, go to WAIT_HI and drop o_trig. Trig high time is therefore TRIG_US ticks, give or take one tick of phase.
  - WAIT_HI: if r_echo[1]=1, go to WAIT_LO. Otherwise, on tick count reaching TIMEOUT_US, pulse o_timeout and go to HOLDOFF.
  - WAIT_LO: if r_echo[1]=0, pulse o_done and go to HOLDOFF. Otherwise, on reaching TIMEOUT_US, pulse o_timeout and go to HOLDOFF (stuck-high echo).
  - HOLDOFF: when r_per_cnt>=PERIOD_US, go to IDLE. An auto-repeat variant exists under the optional feature below.
- o_done and o_timeout are mutually exclusive and are each asserted for exactly one cycle per measurement.
- Simultaneous events: if the echo edge and timeout expiry occur in the same cycle, the echo edge wins.
- Start handling:
  - i_start outside IDLE is ignored; no queuing.
  - i_start held high produces back-to-back measurements at PERIOD_US spacing.
- Echo already high on entry to WAIT_HI (previous echo stuck): move to WAIT_LO immediately. Any resulting timeout is reported normally.
- Reset mid-operation: o_trig drops asynchronously, no o_done/o_timeout pulse is emitted, and the FSM returns to IDLE.

Optional Feature:
- Macro: VLG_TRIG_AUTO_EN.
- When defined, input port i_auto (1 bit) is added. With i_auto=1, HOLDOFF goes directly to TRIG when r_per_cnt>=PERIOD_US, with no i_start needed, giving free-running measurements every PERIOD_US. With i_auto=0, behaviour is identical to the build without the macro.
- When undefined, the port is absent and measurements are single-shot on i_start only.

Test Plan:
- Common setup for all scenarios: TRIG_US=3, TIMEOUT_US=20, PERIOD_US=50, i_clk_en every 4th clock.
1. Normal measurement: pulse i_start, then drive echo high 5 ticks after trig falls and hold it 12 ticks. Required: o_trig high 3 ticks (12±4 clocks), o_done pulses once about 2 clocks after echo falls, no o_timeout, o_busy low again 50 ticks after trig rise.
2. No echo: pulse i_start, keep i_echo=0. Required: o_timeout pulses 20 ticks after trig falls, o_done stays 0, next start accepted only after 50 ticks.
3. Stuck echo: echo rises and never falls. Required: o_timeout pulses 20 ticks after entering WAIT_LO. A new i_start then produces trig, immediately enters WAIT_LO, and times out again.
4. Holdoff and ignored start: pulse i_start during WAIT_LO and during HOLDOFF. Required: no extra trig. A second trig rises no earlier than 50 ticks after the first; i_start held high gives exactly 50-tick spacing.
5. Reset mid-trig: assert i_rst_n=0 during TRIG. Required: o_trig=0 with no clock edge, o_busy=0, no done/timeout pulse, and the next i_start works normally.
6. With VLG_TRIG_AUTO_EN and i_auto=1: required trig rises every 50 ticks with no i_start. Clearing i_auto stops the sequence after the current HOLDOFF.
